alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Drives the 64-bit ALU: accepts one decoded RISC-V op (operands, ALUOp, funct3, funct7[5]) on a
//  valid/ready handshake, generates alu_sel/alu_sub/operands, and captures result, carry and sign.
//  Derives SLT/SLTU (and optionally branch outcome) from the subtract flags, then presents the result
//  on a valid/ready output. Sits between the decode stage and writeback; the ALU is external.
// PARAMETERS
//  XLEN  64  datapath width; shift amount taken from bits [5:0]
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  in_valid       in   1     op presented
//  in_ready       out  1     block can accept op (IDLE only)
//  in_rs1         in   XLEN  operand A
//  in_rs2         in   XLEN  register operand B
//  in_imm         in   XLEN  sign-extended immediate
//  in_use_imm     in   1     1: B = in_imm, 0: B = in_rs2
//  in_aluop       in   2     00 add(ld/st), 01 branch, 10 R-type, 11 I-type
//  in_funct3      in   3     RISC-V funct3
//  in_funct7_5    in   1     funct7[5] (SUB/SRA select)
//  alu_a, alu_b   out  XLEN  ALU operands (registered)
//  alu_sel        out  3     ALU function select (registered)
//  alu_sub        out  1     ALU invert-B/carry-in (registered)
//  alu_result     in   XLEN  ALU_Out
//  alu_carry      in   1     ALU Carry_out
//  alu_sign       in   1     ALU sum[63] (ALU port named zero)
//  out_valid      out  1     result held valid
//  out_ready      in   1     consumer accepts result
//  out_result     out  XLEN  final result
//  out_branch_taken out 1    branch outcome (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; alu_a/alu_b/out_result = 0, alu_sel = 000, alu_sub = 0, out_valid = 0,
//   out_branch_taken = 0; in_ready = 0 while rst_n low, 1 after release. Reset mid-op drops the op.
//  FSM: IDLE -(in_valid)-> ISSUE -> RESP -(out_ready)-> IDLE. in_ready = (state==IDLE).
//  Accept edge registers alu_a=in_rs1, alu_b=mux(in_use_imm), alu_sel/alu_sub from decode.
//  ISSUE (1 cycle): ALU combinational; end-of-cycle captures out_result and flags. out_valid rises the
//   cycle after ISSUE (2 clocks after accept); out_result stable while out_valid && !out_ready.
//  Decode (sel,sub): aluop 00 -> 000,1'b0; 01 -> 000,1; 10/11 by funct3: 000 add (sub = funct7_5 &
//   aluop==10; I-type never subtracts), 001 SLL 110,0; 010 SLT 000,1; 011 SLTU 000,1; 100 XOR 100,0;
//   101 SRL 111 / SRA 101 by funct7_5, 0; 110 OR 011,0; 111 AND 010,0. XOR/AND require sub=0.
//  ovf = (a[63]^b[63]) & (a[63]^alu_sign). SLT result = {63'b0, alu_sign^ovf};
//   SLTU result = {63'b0, ~alu_carry} (carry=1 on sub means A>=B unsigned). Others: alu_result.
//  Branch ops: out_result = A-B; equality from alu_result == 0.
//  Boundaries: in_valid during ISSUE/RESP ignored (in_ready=0); out_ready outside RESP ignored;
//   out_ready held high gives 1 op per 3 clocks; A=B=0 subtract -> carry=1, SLTU=0.
// CONFIGURATION
//  ALU_BRANCH_EN defined: out_branch_taken registered with result for aluop 01: beq eq, bne !eq,
//   blt sign^ovf, bge !(sign^ovf), bltu !carry, bgeu carry, funct3 010/011 -> 0.
//  Undefined: out_branch_taken tied 0; branch ops still return A-B.
// STRUCTURE
//  Package alu_pkg: ALU_SEL_* codes (ADD 000 .. SRL 111), ALUOP_* encodings, state encoding, XLEN.
//  Sub-module alu_op_decode: combinational aluop/funct3/funct7_5 -> {sel, sub, is_slt, is_sltu,
//   is_branch}; top holds FSM, operand/result registers and flag logic.
// TESTING
//  R ADD 0xF+0x3 (aluop 10, f3 000, f7_5 0) -> sel 000 sub 0, out_result 0x12, out_valid 2 clks after accept.
//  R SUB 0x3-0xF -> out_result 0xFFFF_FFFF_FFFF_FFF4; SLT same operands -> 1; SLTU -> 1.
//  SLT A=0x8000_0000_0000_0000, B=1 -> 1 (ovf path); SLTU same -> 0.
//  I SRAI A=0x8000_0000_0000_0000, imm=4, f7_5 1 -> 0xF800_0000_0000_0000; imm 0 f3 000 never subtracts.
//  out_ready low 5 cycles in RESP -> out_result/out_valid held, in_ready 0, new in_valid ignored.
//  ALU_BRANCH_EN: beq 5,5 -> taken 1; bltu 1,0xFFFF.. -> 1; bge -1,0 -> 0; rst_n pulse in ISSUE -> IDLE, out_valid 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: datapath width, ALU
// function-select codes, ALUOp encodings, FSM state encoding and the signed
// overflow helper used by SLT and the branch compares.
package alu_pkg;

  localparam int XLEN = 64;

  // ALU function select codes driven on alu_sel
  localparam logic [2:0] ALU_SEL_ADD = 3'b000;
  localparam logic [2:0] ALU_SEL_AND = 3'b010;
  localparam logic [2:0] ALU_SEL_OR  = 3'b011;
  localparam logic [2:0] ALU_SEL_XOR = 3'b100;
  localparam logic [2:0] ALU_SEL_SRA = 3'b101;
  localparam logic [2:0] ALU_SEL_SLL = 3'b110;
  localparam logic [2:0] ALU_SEL_SRL = 3'b111;

  // ALUOp encodings coming from the main decoder
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  // Two's-complement overflow of A-B: operands differ in sign and the
  // difference's sign differs from A.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sum_msb);
    return (a_msb ^ b_msb) & (a_msb ^ sum_msb);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode-side op handshake and writeback-side result handshake of the ALU
// issue controller. master = producer/consumer environment, slave = controller.
interface alu_issue_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [1:0]      in_aluop;
  logic [2:0]      in_funct3;
  logic            in_funct7_5;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_branch_taken;

  modport master (
    output in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_aluop,
           in_funct3, in_funct7_5, out_ready,
    input  in_ready, out_valid, out_result, out_branch_taken
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_aluop,
           in_funct3, in_funct7_5, out_ready,
    output in_ready, out_valid, out_result, out_branch_taken
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode: ALUOp/funct3/funct7[5] to ALU select,
// subtract enable and the flags telling the controller how to form the result.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] sel,
  output logic       sub,
  output logic       is_slt,
  output logic       is_sltu,
  output logic       is_branch
);

  // Map the decoded op onto ALU controls; SLT/SLTU/branches all subtract
  always_comb begin
    sel       = ALU_SEL_ADD;
    sub       = 1'b0;
    is_slt    = 1'b0;
    is_sltu   = 1'b0;
    is_branch = 1'b0;
    case (aluop)
      ALUOP_ADD: begin
        sel = ALU_SEL_ADD;
        sub = 1'b0;
      end
      ALUOP_BRANCH: begin
        sel       = ALU_SEL_ADD;
        sub       = 1'b1;
        is_branch = 1'b1;
      end
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          3'b000: sub = funct7_5 & (aluop == ALUOP_RTYPE); // ADDI never subtracts
          3'b001: sel = ALU_SEL_SLL;
          3'b010: begin
            sub    = 1'b1;
            is_slt = 1'b1;
          end
          3'b011: begin
            sub     = 1'b1;
            is_sltu = 1'b1;
          end
          3'b100: sel = ALU_SEL_XOR;
          3'b101: sel = funct7_5 ? ALU_SEL_SRA : ALU_SEL_SRL;
          3'b110: sel = ALU_SEL_OR;
          3'b111: sel = ALU_SEL_AND;
          default: sel = ALU_SEL_ADD;
        endcase
      end
      default: sel = ALU_SEL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one decoded op, drives the external ALU for a
// single cycle, forms SLT/SLTU (and branch outcome) from the subtract flags
// and holds the result on a valid/ready output.
// Optional feature: define ALU_BRANCH_EN to compute out_branch_taken.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_if.slave        bus,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [2:0]        alu_sel,
  output logic              alu_sub,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_carry,
  input  logic              alu_sign
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic            alu_sub_q, alu_sub_d;
  logic            is_slt_q, is_slt_d;
  logic            is_sltu_q, is_sltu_d;
  logic            is_branch_q, is_branch_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic            out_valid_q, out_valid_d;

  logic [2:0]      dec_sel_s;
  logic            dec_sub_s;
  logic            dec_slt_s;
  logic            dec_sltu_s;
  logic            dec_branch_s;
  logic            accept_s;
  logic            ovf_s;
  logic            lt_s;
  logic [XLEN-1:0] result_s;

  alu_op_decode u_decode (
    .aluop     (bus.in_aluop),
    .funct3    (bus.in_funct3),
    .funct7_5  (bus.in_funct7_5),
    .sel       (dec_sel_s),
    .sub       (dec_sub_s),
    .is_slt    (dec_slt_s),
    .is_sltu   (dec_sltu_s),
    .is_branch (dec_branch_s)
  );

  assign accept_s     = (state_q == ST_IDLE) & bus.in_valid;
  assign bus.in_ready = (state_q == ST_IDLE) & rst_n;

  // Result selection from the ALU output and subtract flags
  always_comb begin
    ovf_s = signed_ovf(alu_a_q[XLEN-1], alu_b_q[XLEN-1], alu_sign);
    lt_s  = alu_sign ^ ovf_s;
    if (is_branch_q) begin
      result_s = alu_result;
    end else if (is_slt_q) begin
      result_s = {{(XLEN-1){1'b0}}, lt_s};
    end else if (is_sltu_q) begin
      result_s = {{(XLEN-1){1'b0}}, ~alu_carry};  // carry=1 means A>=B unsigned
    end else begin
      result_s = alu_result;
    end
  end

  // FSM next-state plus operand/result register loads
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    alu_sub_d    = alu_sub_q;
    is_slt_d     = is_slt_q;
    is_sltu_d    = is_sltu_q;
    is_branch_d  = is_branch_q;
    out_result_d = out_result_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_ISSUE;
          alu_a_d     = bus.in_rs1;
          alu_b_d     = bus.in_use_imm ? bus.in_imm : bus.in_rs2;
          alu_sel_d   = dec_sel_s;
          alu_sub_d   = dec_sub_s;
          is_slt_d    = dec_slt_s;
          is_sltu_d   = dec_sltu_s;
          is_branch_d = dec_branch_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d      = ST_RESP;
        out_result_d = result_s;
        out_valid_d  = 1'b1;
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= {XLEN{1'b0}};
      alu_b_q      <= {XLEN{1'b0}};
      alu_sel_q    <= ALU_SEL_ADD;
      alu_sub_q    <= 1'b0;
      is_slt_q     <= 1'b0;
      is_sltu_q    <= 1'b0;
      is_branch_q  <= 1'b0;
      out_result_q <= {XLEN{1'b0}};
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      alu_sub_q    <= alu_sub_d;
      is_slt_q     <= is_slt_d;
      is_sltu_q    <= is_sltu_d;
      is_branch_q  <= is_branch_d;
      out_result_q <= out_result_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_sel        = alu_sel_q;
  assign alu_sub        = alu_sub_q;
  assign bus.out_result = out_result_q;
  assign bus.out_valid  = out_valid_q;

`ifdef ALU_BRANCH_EN
  logic [2:0] funct3_q, funct3_d;
  logic       taken_q, taken_d;
  logic       eq_s;

  assign eq_s = (alu_result == {XLEN{1'b0}});

  // Branch condition from funct3, captured alongside the result
  always_comb begin
    funct3_d = funct3_q;
    taken_d  = taken_q;
    if (accept_s) begin
      funct3_d = bus.in_funct3;
    end else begin
      funct3_d = funct3_q;
    end
    if ((state_q == ST_ISSUE) && is_branch_q) begin
      case (funct3_q)
        3'b000:  taken_d = eq_s;
        3'b001:  taken_d = ~eq_s;
        3'b100:  taken_d = lt_s;
        3'b101:  taken_d = ~lt_s;
        3'b110:  taken_d = ~alu_carry;
        3'b111:  taken_d = alu_carry;
        default: taken_d = 1'b0;
      endcase
    end else if (state_q == ST_ISSUE) begin
      taken_d = 1'b0;
    end else begin
      taken_d = taken_q;
    end
  end

  // Branch funct3 and outcome registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= 3'b000;
      taken_q  <= 1'b0;
    end else begin
      funct3_q <= funct3_d;
      taken_q  <= taken_d;
    end
  end

  assign bus.out_branch_taken = taken_q;
`else
  assign bus.out_branch_taken = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, reference model of
// the RISC-V op semantics, expected-result queue and a decoupled output monitor.
module tb_alu_issue_ctrl;

`ifdef ALU_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] res;
    logic        tk;
    longint      vcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_sel;
  logic        alu_sub, alu_carry, alu_sign;
  logic [64:0] sum_s;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  int     rdy_mode = 1;
  exp_t   exp_q[$];

  alu_issue_if bus ();

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_sub    (alu_sub),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_sign   (alu_sign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external ALU behaviour
  always_comb begin
    sum_s     = {1'b0, alu_a} + {1'b0, (alu_sub ? ~alu_b : alu_b)} + {64'd0, alu_sub};
    alu_carry = sum_s[64];
    alu_sign  = sum_s[63];
    case (alu_sel)
      3'b000:  alu_result = sum_s[63:0];
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = $signed(alu_a) >>> alu_b[5:0];
      3'b110:  alu_result = alu_a << alu_b[5:0];
      3'b111:  alu_result = alu_a >> alu_b[5:0];
      default: alu_result = 64'd0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // reference model: {branch_taken, result}
  function automatic logic [64:0] model(input logic [1:0] aluop, input logic [2:0] f3,
                                        input logic f7, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] r;
    logic        t;
    t = 1'b0;
    r = 64'd0;
    case (aluop)
      2'b00: r = a + b;
      2'b01: begin
        r = a - b;
        case (f3)
          3'b000:  t = (a == b);
          3'b001:  t = (a != b);
          3'b100:  t = ($signed(a) < $signed(b));
          3'b101:  t = ($signed(a) >= $signed(b));
          3'b110:  t = (a < b);
          3'b111:  t = (a >= b);
          default: t = 1'b0;
        endcase
        t = t & BR_EN;
      end
      default: begin
        case (f3)
          3'b000:  r = (aluop == 2'b10 && f7) ? a - b : a + b;
          3'b001:  r = a << b[5:0];
          3'b010:  r = {63'd0, ($signed(a) < $signed(b))};
          3'b011:  r = {63'd0, (a < b)};
          3'b100:  r = a ^ b;
          3'b101:  r = f7 ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
          3'b110:  r = a | b;
          default: r = a & b;
        endcase
      end
    endcase
    return {t, r};
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 20));
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {32'd0, $urandom};
    endcase
  endfunction

  task automatic drive_garbage();
    bus.in_rs1      = rand_operand();
    bus.in_rs2      = rand_operand();
    bus.in_imm      = rand_operand();
    bus.in_use_imm  = 1'($urandom_range(0, 1));
    bus.in_aluop    = 2'($urandom_range(0, 3));
    bus.in_funct3   = 3'($urandom_range(0, 7));
    bus.in_funct7_5 = 1'($urandom_range(0, 1));
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                      input logic [63:0] a, input logic [63:0] rs2, input logic [63:0] imm,
                      input logic use_imm, input bit have_exp, input logic [63:0] xr,
                      input logic xt);
    int   n;
    exp_t e;
    logic [64:0] m;
    n = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      drive_garbage();
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      fail_now("accept_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    bus.in_rs1      = a;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
    bus.in_use_imm  = use_imm;
    bus.in_aluop    = aluop;
    bus.in_funct3   = f3;
    bus.in_funct7_5 = f7;
    m = model(aluop, f3, f7, a, use_imm ? imm : rs2);
    e.res  = have_exp ? xr : m[63:0];
    e.tk   = have_exp ? xt : m[64];
    e.vcyc = cyc + 2;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  // consumer ready pattern, changed just after each rising edge
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // output monitor: latency, hold stability and scoreboard compare
  logic        prev_valid = 1'b0;
  logic        held = 1'b0;
  logic [63:0] held_res;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      held       = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_valid");
        else chk("latency_cycle", 64'(cyc), 64'(exp_q[0].vcyc));
      end
      if (bus.out_valid && held) chk("hold_result", bus.out_result, held_res);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("result_without_expect");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", bus.out_result, e.res);
          chk("branch_taken", {63'd0, bus.out_branch_taken}, {63'd0, e.tk});
        end
        held = 1'b0;
      end else if (bus.out_valid) begin
        held     = 1'b1;
        held_res = bus.out_result;
      end else begin
        held = 1'b0;
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    drive_garbage();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_sel_sub", {60'd0, alu_sel, alu_sub}, 64'd0);
    chk("rst_taken", {63'd0, bus.out_branch_taken}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

    // directed cases
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    send(2'b10, 3'b000, 1'b0, 64'hF, 64'h3, 64'd0, 1'b0, 1'b1, 64'h12, 1'b0);
    chk("add_sel_sub", {60'd0, alu_sel, alu_sub}, 64'd0);
    send(2'b10, 3'b000, 1'b1, 64'h3, 64'hF, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    chk("sub_sub", {63'd0, alu_sub}, 64'd1);
    send(2'b10, 3'b010, 1'b0, 64'h3, 64'hF, 64'd0, 1'b0, 1'b1, 64'd1, 1'b0);
    send(2'b10, 3'b011, 1'b0, 64'h3, 64'hF, 64'd0, 1'b0, 1'b1, 64'd1, 1'b0);
    send(2'b10, 3'b010, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b0, 1'b1, 64'd1, 1'b0);
    send(2'b10, 3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0);
    send(2'b11, 3'b101, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 1'b1, 1'b1,
         64'hF800_0000_0000_0000, 1'b0);
    chk("srai_sel", {61'd0, alu_sel}, 64'd5);
    send(2'b11, 3'b000, 1'b1, 64'd5, 64'd9, 64'd0, 1'b1, 1'b1, 64'd5, 1'b0);
    chk("addi_no_sub", {63'd0, alu_sub}, 64'd0);
    send(2'b10, 3'b011, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0);
    send(2'b01, 3'b000, 1'b0, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1, 64'd0, BR_EN);
    send(2'b01, 3'b110, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'd2, BR_EN);
    send(2'b01, 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b0, 1'b1,
         64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drain();

    // consumer stalls: result held, new ops ignored
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    send(2'b10, 3'b100, 1'b0, 64'h00FF, 64'h0F0F, 64'd0, 1'b0, 1'b1, 64'h0FF0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      drive_garbage();
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rdy_mode = 1;
    drain();

    // reset while in ISSUE drops the op
    send(2'b00, 3'b000, 1'b0, 64'd7, 64'd8, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {63'd0, bus.in_ready}, 64'd1);
    chk("midrst_valid_low", {63'd0, bus.out_valid}, 64'd0);

    // randomized ops with random consumer backpressure
    rdy_mode = 0;
    for (int k = 0; k < 300; k++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           rand_operand(), rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
           1'b0, 64'd0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rdy_mode = 1;
    drain();
    repeat (3) @(negedge clk);
    chk("final_idle", {63'd0, bus.in_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
